// File: rtl/pipe_add_sub_pkg.sv
// Shared constants for the pipelined adder/subtractor.
//   DEF_WIDTH  : default operand/result width in bits
//   DEF_CHUNK  : default bits resolved per pipeline stage
//   DEF_STAGES : derived stage count (DEF_WIDTH / DEF_CHUNK)
// eff_carry_in() gives the carry fed into stage 0 for the selected mode.
package pipe_add_sub_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_CHUNK  = 16;
    localparam int DEF_STAGES = DEF_WIDTH / DEF_CHUNK;

    // Subtraction is a + ~b + 1, so the caller's carry-in is overridden by 1.
    function automatic logic eff_carry_in(input logic sub, input logic cin);
        return sub | cin;
    endfunction

endpackage

// File: rtl/add_stage.sv
// One CHUNK-bit ripple-carry adder slice.
//   a, b : chunk operands (b already inverted for subtraction)
//   ci   : carry into bit 0
//   s    : chunk sum
//   co   : carry out of bit CHUNK-1
//   cm   : carry into bit CHUNK-1 (used for signed overflow at the top slice)
module add_stage
    import pipe_add_sub_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             cm
);

    logic [CHUNK:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[CHUNK];
    assign cm = c[CHUNK - 1];

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor, CHUNK bits resolved per stage,
// valid/ready handshake on both sides, latency STAGES cycles.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand beat handshake (in_ready = advance)
//   a, b, cin, sub        : operands, carry-in (ignored for sub), mode
//   out_valid / out_ready : result beat handshake
//   sum, cout, ovf        : result, carry out (1 = no borrow for sub),
//                           signed overflow
module pipe_add_sub
    import pipe_add_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             advance;

    // Each stage carries one WIDTH-bit word that rotates right by a chunk per
    // stage: finished sum chunks enter at the top, the pending a chunk sits at
    // the bottom. After the last stage the word is exactly the aligned sum.
    logic [WIDTH-1:0] x_in  [STAGES];
    logic [WIDTH-1:0] x_nxt [STAGES];
    logic [WIDTH-1:0] x_q   [STAGES];
    // Remaining effective-b chunks, shifted down so the next chunk is at bit 0.
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] b_nxt [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [CHUNK-1:0] s_c   [STAGES];

    logic [STAGES-1:0] ci;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] co_c;
    logic [STAGES-1:0] cm_c;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic              ovf_q;

    // Only the top slice's carry-into-MSB and none of the final b word matter.
    logic              unused_tail;

    assign b_eff    = sub ? ~b : b;
    assign cin_eff  = eff_carry_in(sub, cin);
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_src
            assign x_in[k] = a;
            assign b_in[k] = b_eff;
            assign ci[k]   = cin_eff;
            assign v_in[k] = in_valid;
        end else begin : g_src
            assign x_in[k] = x_q[k - 1];
            assign b_in[k] = b_q[k - 1];
            assign ci[k]   = c_q[k - 1];
            assign v_in[k] = v_q[k - 1];
        end

        add_stage #(.CHUNK(CHUNK)) u_add (
            .a  (x_in[k][CHUNK-1:0]),
            .b  (b_in[k][CHUNK-1:0]),
            .ci (ci[k]),
            .s  (s_c[k]),
            .co (co_c[k]),
            .cm (cm_c[k])
        );

        assign x_nxt[k] = (x_in[k] >> CHUNK) | (WIDTH'(s_c[k]) << (WIDTH - CHUNK));
        assign b_nxt[k] = b_in[k] >> CHUNK;
    end

    // Data registers load only for valid slots so bubbles leave the previous
    // contents untouched (and outputs stay at zero after reset until a beat).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                x_q[k] <= '0;
                b_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                if (v_in[k]) begin
                    c_q[k] <= co_c[k];
                    x_q[k] <= x_nxt[k];
                    b_q[k] <= b_nxt[k];
                end
            end
            if (v_in[STAGES-1]) begin
                ovf_q <= co_c[STAGES-1] ^ cm_c[STAGES-1];
            end
        end
    end

    assign unused_tail = ^{b_q[STAGES-1], cm_c};

    assign out_valid = v_q[STAGES-1];
    assign sum       = x_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: doc/pipe_add_sub.md
PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

Interface
REQ-001 WIDTH, 64, operand and result width in bits; SHALL be a multiple of CHUNK.
REQ-002 CHUNK, 16, bits added per pipeline stage; STAGES = WIDTH/CHUNK SHALL be at least 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 cin  input  1  carry-in; ignored when sub=1.
REQ-010 sub  input  1  mode: 0 computes a+b+cin, 1 computes a-b (a + ~b + 1).
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 sum  output  WIDTH  result bits.
REQ-014 cout  output  1  carry out of bit WIDTH-1; for sub, 1 means no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow of the selected operation.

Function
REQ-016 A beat SHALL be accepted when in_valid and in_ready are both 1 on a clock edge.
REQ-017 A result SHALL be consumed when out_valid and out_ready are both 1 on a clock edge.
REQ-018 advance = !out_valid | out_ready; in_ready SHALL equal advance, combinationally; the pipeline SHALL move only when advance=1.
REQ-019 Stage k (0..STAGES-1) SHALL add chunk k of a and of the effective b with the carry registered from stage k-1; stage 0 uses effective carry-in (sub ? 1 : cin).
REQ-020 Upper operand chunks SHALL be skew-registered alongside the pipeline; lower result chunks SHALL be delay-aligned so that all sum bits leave together.
REQ-021 Latency SHALL be exactly STAGES cycles from acceptance to out_valid=1 when out_ready is held 1.
REQ-022 Throughput SHALL be one beat per cycle with no stall; bubbles (accept cycles with in_valid=0) SHALL propagate as invalid slots.
REQ-023 When out_valid=1 and out_ready=0, sum, cout, ovf and out_valid SHALL hold stable and no beat SHALL be lost, duplicated or reordered.
REQ-024 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-025 Results SHALL wrap modulo 2^WIDTH; no saturation.
REQ-026 Simultaneous consume and accept in one cycle SHALL be legal and lossless.

Reset
REQ-027 While rst=1, all valid bits, carries and data registers SHALL be 0 immediately, independent of clk.
REQ-028 Outputs under reset: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
REQ-029 Beats in flight at reset assertion SHALL be discarded; none SHALL emerge after release.

Structure
REQ-030 A shared package SHALL hold default WIDTH and CHUNK and the derived STAGES constant.
REQ-031 One sub-module, add_stage, SHALL implement a CHUNK-bit ripple adder with carry-in, carry-out and carry-into-MSB; pipe_add_sub SHALL instantiate STAGES copies.

Verification (WIDTH=64, CHUNK=16, STAGES=4)
REQ-032 Reset: rst pulse -> out_valid=0, in_ready=1, sum=0 during and after reset.
REQ-033 a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0, out_ready=1 -> sum=0, cout=1, ovf=0, out_valid exactly 4 cycles after accept.
REQ-034 a=0x8000_0000_0000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
REQ-035 a=0x0000_0000_0000_FFFF, b=1, cin=1, sub=0 -> sum=0x0000_0000_0001_0001 (carry crosses chunk 0/1 boundary), cout=0, ovf=0.
REQ-036 8 back-to-back random beats with out_ready toggling 1,0,0,1,... -> results match reference model in order; in_ready=0 exactly when out_valid=1 and out_ready=0.
REQ-037 rst asserted with 3 beats in flight -> out_valid=0 immediately; after release, no stale result appears before a new beat is accepted.
